asm_ctrl_sequencer: RTL and testbench
=====================================

Name: asm_ctrl_sequencer

Overview:
- Microcoded controller that drives a generated datapath `top`: register enables, mux selects and functional-unit strobes, bundled as one control word.
- Replaces the hard-coded FSM case with a loadable control store. A host writes the microprogram, then issues operand/start transactions.
- The sequencer steps through the microprogram, waits out the datapath pipeline latency, captures the datapath result and returns it over a valid/ready handshake.

Parameters:
- WIDTH, 32, operand/result data width.
- CW, 8, control-word width driven to the datapath.
- SW, 4, control-store address width (2**SW microwords).
- RES_LAT, 2, cycles from the last microword to a valid datapath result (0..15).
- MAX_STEPS, 64, watchdog limit on microwords executed per run.

Ports:
- clk  in  1  clock, all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- prog_we  in  1  control-store write strobe.
- prog_addr  in  SW  control-store write address.
- prog_data  in  1+SW+CW  microword {last, next[SW-1:0], ctrl[CW-1:0]}.
- prog_err  out  1  one-cycle pulse: a write was rejected because the block is busy.
- in_valid  in  1  operand/start request.
- in_ready  out  1  high only in IDLE.
- in_a, in_b  in  WIDTH  operands.
- op_a, op_b  out  WIDTH  operands latched on the start handshake, driven to the datapath.
- ctrl  out  CW  current control word.
- dp_result  in  WIDTH  datapath result.
- out_valid  out  1  result available.
- out_ready  in  1  host accepts result.
- out_data  out  WIDTH  captured result.
- abort  out  1  one-cycle pulse when the watchdog fires.

Behaviour:
- Reset (asynchronous, any state):
  - state=IDLE, pc=0, step count=0, latency count=0.
  - ctrl=0, op_a=op_b=0, out_data=0, out_valid=0, prog_err=0, abort=0.
  - The control store is not cleared.
- Control store write: synchronous. In IDLE, prog_we writes prog_data at prog_addr. Outside IDLE the write is dropped and prog_err pulses on the next cycle.
- IDLE:
  - in_ready=1, ctrl=0.
  - On in_valid&&in_ready: latch in_a/in_b into op_a/op_b, pc<=0, step count<=0, go to RUN.
- RUN:
  - Each cycle, ctrl is driven from store[pc] as a registered output. The word at address 0 appears on ctrl on the first RUN cycle, i.e. the cycle after the handshake.
  - Transition rule, taken after the word is presented:
    - If the word's last=0: pc<=next.
    - If last=1: latency count<=RES_LAT and go to WAIT; ctrl returns to 0 the following cycle.
  - Step count increments per word. When MAX_STEPS words have been presented without last: ctrl<=0, abort pulses, return to IDLE with no result.
- WAIT:
  - ctrl=0; the latency count decrements once per cycle.
  - With count=0 (including RES_LAT=0, where WAIT lasts one cycle): out_data<=dp_result, out_valid<=1, go to DONE.
  - Total latency from start handshake to out_valid = N words + RES_LAT + 2 cycles.
- DONE:
  - out_valid and out_data hold stable until out_ready.
  - On out_valid&&out_ready: out_valid<=0 and go to IDLE. in_ready rises on the next cycle; there is no same-cycle turnaround.
- Simultaneous events:
  - prog_we together with a start handshake in IDLE: the write commits, and the run reads the updated store.
  - in_valid is ignored outside IDLE.
- Wrap-around: next may point to any address, loops included. Loops are bounded only by the watchdog.
- Arithmetic: step count is clog2(MAX_STEPS+1) bits wide and saturates at the compare. The latency count is 4 bits.

Decomposition:
- Shared package asm_pkg holds:
  - the state encoding (IDLE, RUN, WAIT, DONE);
  - the microword field offsets, with MW = 1+SW+CW;
  - the function extracting the last/next/ctrl fields.
- One sub-module: asm_ctrl_store, a 2**SW x MW register array with a synchronous write port and a combinational read port. The top level holds the FSM, the counters and the handshakes.

Test Plan:
- Program 0:{0,1,0x11}, 1:{0,2,0x22}, 2:{1,0,0x44}; start with a=3, b=5 -> ctrl reads 0x11, 0x22, 0x44 on consecutive cycles, then 0; with RES_LAT=2 and dp_result=15, out_valid rises 7 cycles after the handshake with out_data=15; op_a=3, op_b=5 for the whole run.
- Hold out_ready low 5 cycles in DONE -> out_valid/out_data stable and in_ready=0; raise out_ready -> out_valid drops, in_ready=1 the next cycle.
- Program 0:{0,0,0x01} (self loop) -> exactly 64 cycles of ctrl=0x01, then a single abort pulse, ctrl=0, return to IDLE, no out_valid.
- Assert prog_we during RUN -> prog_err pulses once; rerunning the program gives unchanged ctrl sequence.
- Assert reset asynchronously mid-RUN (between clock edges) -> ctrl, out_valid and in_ready reach reset values immediately; after release, a fresh start executes from address 0 using the preserved store.
- RES_LAT=0, single word {1,0,0xA5} -> ctrl=0xA5 for one cycle, out_valid 3 cycles after the handshake.

Source files
------------

// File: rtl/asm_pkg.sv
`default_nettype none
// ============================================================================
// asm_pkg : shared state encoding and microword field helpers
// Rev 1.0 : initial release
// ============================================================================
package asm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Widest microword the helpers accept; callers zero-extend to MW_MAX.
  localparam int SW_MAX = 8;
  localparam int CW_MAX = 32;
  localparam int MW_MAX = 1 + SW_MAX + CW_MAX;

  // Microword layout: {last, next[sw-1:0], ctrl[cw-1:0]}
  function automatic int mw_width(input int sw, input int cw);
    return 1 + sw + cw;
  endfunction

  function automatic int mw_next_lo(input int cw);
    return cw;
  endfunction

  function automatic int mw_last_pos(input int sw, input int cw);
    return sw + cw;
  endfunction

  function automatic logic mw_last(input logic [MW_MAX-1:0] word, input int sw, input int cw);
    return 1'(word >> mw_last_pos(sw, cw));
  endfunction

  function automatic logic [SW_MAX-1:0] mw_next(input logic [MW_MAX-1:0] word, input int sw,
                                                input int cw);
    return SW_MAX'((word >> mw_next_lo(cw)) & ((MW_MAX'(1) << sw) - MW_MAX'(1)));
  endfunction

  function automatic logic [CW_MAX-1:0] mw_ctrl(input logic [MW_MAX-1:0] word, input int cw);
    return CW_MAX'(word & ((MW_MAX'(1) << cw) - MW_MAX'(1)));
  endfunction

endpackage
`default_nettype wire

// File: rtl/asm_ctrl_store.sv
`default_nettype none
// ============================================================================
// asm_ctrl_store : 2**SW x MW microprogram store, sync write / async read
// Rev 1.0 : initial release
// ============================================================================
module asm_ctrl_store
  import asm_pkg::*;
#(
  parameter int SW = 4,
  parameter int CW = 8
) (
  input  logic                        clk,
  input  logic                        we,
  input  logic [SW-1:0]               waddr,
  input  logic [mw_width(SW, CW)-1:0] wdata,
  input  logic [SW-1:0]               raddr,
  output logic [mw_width(SW, CW)-1:0] rdata
);

  localparam int MW    = mw_width(SW, CW);
  localparam int DEPTH = 1 << SW;

  // No reset: the microprogram survives a controller reset.
  logic [MW-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule
`default_nettype wire

// File: rtl/asm_ctrl_sequencer.sv
`default_nettype none
// ============================================================================
// asm_ctrl_sequencer : microcoded controller for the generated datapath
// Rev 1.0 : initial release
// ============================================================================
module asm_ctrl_sequencer
  import asm_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int CW        = 8,
  parameter int SW        = 4,
  parameter int RES_LAT   = 2,
  parameter int MAX_STEPS = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             prog_we,
  input  logic [SW-1:0]    prog_addr,
  input  logic [SW+CW:0]   prog_data,
  output logic             prog_err,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  output logic [CW-1:0]    ctrl,
  input  logic [WIDTH-1:0] dp_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             abort
);

  localparam int                MW         = mw_width(SW, CW);
  localparam int                STEP_W     = $clog2(MAX_STEPS + 1);
  localparam logic [STEP_W-1:0] STEP_LIMIT = STEP_W'(MAX_STEPS);
  localparam logic [3:0]        LAT_INIT   = 4'(RES_LAT);

  state_e            state_q, state_d;
  logic [SW-1:0]     pc_q, pc_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [3:0]        lat_q, lat_d;
  logic              last_q, last_d;
  logic [SW-1:0]     next_q, next_d;
  logic [CW-1:0]     ctrl_q, ctrl_d;
  logic [WIDTH-1:0]  op_a_q, op_a_d;
  logic [WIDTH-1:0]  op_b_q, op_b_d;
  logic [WIDTH-1:0]  out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              prog_err_q, prog_err_d;
  logic              abort_q, abort_d;

  logic              w_store_we;
  logic [MW-1:0]     w_store_rd;
  logic [MW-1:0]     w_rd_word;
  logic              w_rd_last;
  logic [SW-1:0]     w_rd_next;
  logic [CW-1:0]     w_rd_ctrl;
  logic [STEP_W-1:0] w_step_inc;

  assign w_store_we = prog_we && (state_q == ST_IDLE);
  assign w_step_inc = step_q + 1'b1;

  // The store is read at the address of the word presented next cycle.
  always_comb begin
    pc_d = pc_q;
    if (state_q == ST_IDLE && in_valid) begin
      pc_d = '0;
    end else if (state_q == ST_RUN && !last_q) begin
      pc_d = next_q;
    end
  end

  asm_ctrl_store #(
    .SW (SW),
    .CW (CW)
  ) u_store (
    .clk   (clk),
    .we    (w_store_we),
    .waddr (prog_addr),
    .wdata (prog_data),
    .raddr (pc_d),
    .rdata (w_store_rd)
  );

  // Forward a write that lands on the same edge as the start handshake.
  assign w_rd_word = (w_store_we && prog_addr == pc_d) ? prog_data : w_store_rd;
  assign w_rd_last = mw_last(MW_MAX'(w_rd_word), SW, CW);
  assign w_rd_next = SW'(mw_next(MW_MAX'(w_rd_word), SW, CW));
  assign w_rd_ctrl = CW'(mw_ctrl(MW_MAX'(w_rd_word), CW));

  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    lat_d       = lat_q;
    last_d      = last_q;
    next_d      = next_q;
    ctrl_d      = ctrl_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    abort_d     = 1'b0;
    prog_err_d  = prog_we && (state_q != ST_IDLE);

    case (state_q)
      ST_IDLE: begin
        ctrl_d = '0;
        if (in_valid) begin
          op_a_d  = in_a;
          op_b_d  = in_b;
          step_d  = '0;
          ctrl_d  = w_rd_ctrl;
          last_d  = w_rd_last;
          next_d  = w_rd_next;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        step_d = w_step_inc;
        if (last_q) begin
          ctrl_d  = '0;
          lat_d   = LAT_INIT;
          state_d = ST_WAIT;
        end else if (w_step_inc == STEP_LIMIT) begin
          ctrl_d  = '0;
          abort_d = 1'b1;
          state_d = ST_IDLE;
        end else begin
          ctrl_d = w_rd_ctrl;
          last_d = w_rd_last;
          next_d = w_rd_next;
        end
      end
      ST_WAIT: begin
        ctrl_d = '0;
        if (lat_q == 4'd0) begin
          out_data_d  = dp_result;
          out_valid_d = 1'b1;
          state_d     = ST_DONE;
        end else begin
          lat_d = lat_q - 4'd1;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      pc_q        <= '0;
      step_q      <= '0;
      lat_q       <= '0;
      last_q      <= 1'b0;
      next_q      <= '0;
      ctrl_q      <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      prog_err_q  <= 1'b0;
      abort_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      step_q      <= step_d;
      lat_q       <= lat_d;
      last_q      <= last_d;
      next_q      <= next_d;
      ctrl_q      <= ctrl_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      prog_err_q  <= prog_err_d;
      abort_q     <= abort_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign ctrl      = ctrl_q;
  assign op_a      = op_a_q;
  assign op_b      = op_b_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign prog_err  = prog_err_q;
  assign abort     = abort_q;

endmodule
`default_nettype wire

// File: tb/tb_asm_ctrl_sequencer.sv
`default_nettype none
// ============================================================================
// tb_asm_ctrl_sequencer : vector table + scoreboard bench for the sequencer
// Rev 1.0 : initial release
// ============================================================================
module tb_asm_ctrl_sequencer;

  localparam int WIDTH = 32, CW = 8, SW = 4, MW = 13, RES_LAT = 2;

  logic             clk = 1'b0, reset = 1'b1;
  logic             prog_we = 1'b0, prog_err;
  logic [SW-1:0]    prog_addr = '0;
  logic [MW-1:0]    prog_data = '0;
  logic             in_valid = 1'b0, in_ready;
  logic [WIDTH-1:0] in_a = '0, in_b = '0, op_a, op_b;
  logic [CW-1:0]    ctrl;
  logic [WIDTH-1:0] dp_result = '0, out_data;
  logic             out_valid, out_ready = 1'b0, abort;

  logic             z_prog_we = 1'b0, z_prog_err;
  logic [SW-1:0]    z_prog_addr = '0;
  logic [MW-1:0]    z_prog_data = '0;
  logic             z_in_valid = 1'b0, z_in_ready;
  logic [WIDTH-1:0] z_in_a = '0, z_in_b = '0, z_op_a, z_op_b;
  logic [CW-1:0]    z_ctrl;
  logic [WIDTH-1:0] z_dp_result = '0, z_out_data;
  logic             z_out_valid, z_out_ready = 1'b0, z_abort;

  asm_ctrl_sequencer #(.WIDTH(WIDTH), .CW(CW), .SW(SW), .RES_LAT(RES_LAT), .MAX_STEPS(64)) dut (
    .clk(clk), .reset(reset), .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .prog_err(prog_err), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .op_a(op_a), .op_b(op_b), .ctrl(ctrl), .dp_result(dp_result), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .abort(abort));

  asm_ctrl_sequencer #(.WIDTH(WIDTH), .CW(CW), .SW(SW), .RES_LAT(0), .MAX_STEPS(64)) dut0 (
    .clk(clk), .reset(reset), .prog_we(z_prog_we), .prog_addr(z_prog_addr),
    .prog_data(z_prog_data), .prog_err(z_prog_err), .in_valid(z_in_valid),
    .in_ready(z_in_ready), .in_a(z_in_a), .in_b(z_in_b), .op_a(z_op_a), .op_b(z_op_b),
    .ctrl(z_ctrl), .dp_result(z_dp_result), .out_valid(z_out_valid),
    .out_ready(z_out_ready), .out_data(z_out_data), .abort(z_abort));

  always #5 clk = ~clk;

  typedef struct {
    int                  nprog;
    logic [2:0][SW-1:0]  addr;
    logic [2:0][MW-1:0]  data;
    logic [WIDTH-1:0]    a, b, dp;
    int                  hold;
    bit                  sim_we;
    logic [SW-1:0]       sim_addr;
    logic [MW-1:0]       sim_data;
    int                  err_cyc;
  } vec_t;

  typedef struct {
    logic [WIDTH-1:0] data;
    int               cyc;
  } res_t;

  vec_t          vecs[6];
  logic [CW-1:0] exp_ctrl_q[$];
  res_t          exp_res_q[$];
  logic [MW-1:0] shadow[16];
  int            n_checks = 0;
  int            n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  function automatic logic [MW-1:0] mw(input logic l, input logic [SW-1:0] n, input logic [CW-1:0] c);
    return {l, n, c};
  endfunction

  // Reference walk of the shadow store: expected ctrl stream plus abort verdict.
  task automatic model_walk(output bit aborted, output int nw);
    logic [SW-1:0] pc;
    logic [MW-1:0] w;
    pc = '0;
    nw = 0;
    aborted = 1'b0;
    for (int s = 0; s < 64; s++) begin
      w = shadow[pc];
      exp_ctrl_q.push_back(w[CW-1:0]);
      nw++;
      if (w[MW-1]) return;
      pc = w[CW+SW-1:CW];
    end
    aborted = 1'b1;
  endtask

  task automatic prog_write(input logic [SW-1:0] addr, input logic [MW-1:0] data);
    @(negedge clk);
    prog_we = 1'b1; prog_addr = addr; prog_data = data;
    shadow[addr] = data;
    @(negedge clk);
    prog_we = 1'b0;
  endtask

  task automatic run(input logic [WIDTH-1:0] a, b, dp, input int hold, input bit sim_we,
                     input logic [SW-1:0] sim_addr, input logic [MW-1:0] sim_data,
                     input int err_cyc);
    bit            aborted, ev;
    int            nw, guard, last;
    res_t          r;
    logic [CW-1:0] ec;
    guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check("start_in_ready", in_ready, 1);
    in_valid = 1'b1; in_a = a; in_b = b; dp_result = dp;
    if (sim_we) begin
      prog_we = 1'b1; prog_addr = sim_addr; prog_data = sim_data;
      shadow[sim_addr] = sim_data;
    end
    model_walk(aborted, nw);
    if (!aborted) exp_res_q.push_back('{dp, nw + RES_LAT + 2});
    last = aborted ? nw + 1 : nw + RES_LAT + 2;
    @(negedge clk);
    in_valid = 1'b0; prog_we = 1'b0; in_a = ~a; in_b = ~b;
    for (int cyc = 1; cyc <= last; cyc++) begin
      ec = (exp_ctrl_q.size() > 0) ? exp_ctrl_q.pop_front() : '0;
      check("ctrl", ctrl, ec);
      check("op_a", op_a, a);
      check("op_b", op_b, b);
      check("run_in_ready", in_ready, aborted && cyc == last);
      check("abort", abort, aborted && cyc == last);
      check("prog_err", prog_err, err_cyc != 0 && cyc == err_cyc + 1);
      ev = (exp_res_q.size() > 0) && (cyc == exp_res_q[0].cyc);
      check("out_valid", out_valid, ev);
      if (out_valid === 1'b1 && exp_res_q.size() > 0) begin
        r = exp_res_q.pop_front();
        check("out_data", out_data, r.data);
      end
      if (err_cyc != 0 && cyc == err_cyc) begin
        prog_we = 1'b1; prog_addr = 4'd1; prog_data = 13'h1FFF;
      end else begin
        prog_we = 1'b0;
      end
      if (cyc < last) @(negedge clk);
    end
    prog_we = 1'b0;
    check("ctrl_q_drained", exp_ctrl_q.size(), 0);
    check("res_q_drained", exp_res_q.size(), 0);
    exp_ctrl_q.delete();
    exp_res_q.delete();
    if (aborted) begin
      @(negedge clk);
      check("abort_pulse_end", abort, 0);
      check("abort_no_valid", out_valid, 0);
      check("abort_idle", in_ready, 1);
    end else begin
      for (int h = 0; h < hold; h++) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", out_data, dp);
        check("hold_in_ready", in_ready, 0);
        @(negedge clk);
      end
      out_ready = 1'b1;
      check("accept_in_ready", in_ready, 0);
      @(negedge clk);
      out_ready = 1'b0;
      check("post_valid", out_valid, 0);
      check("post_in_ready", in_ready, 1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, want finished");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{3, {4'd2, 4'd1, 4'd0}, {mw(1, 0, 8'h44), mw(0, 2, 8'h22), mw(0, 1, 8'h11)},
                32'd3, 32'd5, 32'd15, 5, 1'b0, 4'd0, 13'd0, 0};
    vecs[1] = '{0, '0, '0, 32'hFFFF_FFFF, 32'd0, 32'hDEAD_BEEF, 0, 1'b0, 4'd0, 13'd0, 2};
    vecs[2] = '{0, '0, '0, 32'd1, 32'd2, 32'h55AA_55AA, 1, 1'b0, 4'd0, 13'd0, 0};
    vecs[3] = '{3, {4'd1, 4'd3, 4'd0}, {mw(1, 0, 8'h81), mw(0, 1, 8'h3C), mw(0, 3, 8'h5A)},
                32'h1234_5678, 32'h9ABC_DEF0, 32'hCAFE_F00D, 2, 1'b0, 4'd0, 13'd0, 0};
    vecs[4] = '{0, '0, '0, 32'hA, 32'hB, 32'h0F0F_0F0F, 0, 1'b1, 4'd0, mw(0, 1, 8'h99), 0};
    vecs[5] = '{1, {4'd0, 4'd0, 4'd0}, {13'd0, 13'd0, mw(0, 0, 8'h01)},
                32'hC, 32'hD, 32'h1234, 0, 1'b0, 4'd0, 13'd0, 0};

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("reset_ctrl", ctrl, 0);
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_out_data", out_data, 0);
    check("reset_op_a", op_a, 0);
    check("reset_abort", abort, 0);
    check("reset_prog_err", prog_err, 0);
    reset = 1'b0;

    for (int i = 0; i < 6; i++) begin
      for (int k = 0; k < vecs[i].nprog; k++) prog_write(vecs[i].addr[k], vecs[i].data[k]);
      run(vecs[i].a, vecs[i].b, vecs[i].dp, vecs[i].hold, vecs[i].sim_we,
          vecs[i].sim_addr, vecs[i].sim_data, vecs[i].err_cyc);
    end

    // Asynchronous reset between edges in the middle of a run
    prog_write(4'd0, mw(0, 1, 8'h11));
    @(negedge clk);
    in_valid = 1'b1; in_a = 32'h77; in_b = 32'h99;
    @(negedge clk);
    in_valid = 1'b0;
    check("arst_pre_ctrl", ctrl, 8'h11);
    #2 reset = 1'b1;
    #1;
    check("arst_ctrl", ctrl, 0);
    check("arst_in_ready", in_ready, 1);
    check("arst_out_valid", out_valid, 0);
    check("arst_out_data", out_data, 0);
    check("arst_op_a", op_a, 0);
    @(negedge clk);
    reset = 1'b0;
    run(32'h42, 32'h24, 32'hFEED_FACE, 1, 1'b0, 4'd0, 13'd0, 0);

    // Zero result latency: WAIT lasts one cycle
    @(negedge clk);
    z_prog_we = 1'b1; z_prog_addr = 4'd0; z_prog_data = mw(1, 0, 8'hA5);
    @(negedge clk);
    z_prog_we = 1'b0; z_in_valid = 1'b1; z_in_a = 32'h5; z_in_b = 32'h6;
    z_dp_result = 32'h0BAD_F00D;
    @(negedge clk);
    z_in_valid = 1'b0;
    check("lat0_c1_ctrl", z_ctrl, 8'hA5);
    check("lat0_c1_valid", z_out_valid, 0);
    @(negedge clk);
    check("lat0_c2_ctrl", z_ctrl, 0);
    check("lat0_c2_valid", z_out_valid, 0);
    @(negedge clk);
    check("lat0_c3_valid", z_out_valid, 1);
    check("lat0_c3_data", z_out_data, 32'h0BAD_F00D);
    check("lat0_op_a", z_op_a, 32'h5);
    z_out_ready = 1'b1;
    @(negedge clk);
    z_out_ready = 1'b0;
    check("lat0_post_valid", z_out_valid, 0);
    check("lat0_post_ready", z_in_ready, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
